// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Fetch entries pair the fetch address with the word memory returned for it.
package if_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction memory is word addressed; redirect targets drop their byte offset.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bus between the fetch unit (master), its instruction memory and the IF/ID stage (slave).
// Handshake: pc/inst are consumed on a cycle with valid && !stall && !jmp; they hold otherwise.
interface if_fetch_if;
    import if_pkg::*;

    logic              stall;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_target;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;

    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;

    modport master (
        input  stall, jmp, jmp_target, imem_rdata,
        output imem_req, imem_addr, pc, inst, valid
    );

    modport slave (
        output stall, jmp, jmp_target, imem_rdata,
        input  imem_req, imem_addr, pc, inst, valid
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that beats a same-cycle push.
// The head is read combinationally so the fetch output follows the buffer with no extra stage.
module fetch_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= next_ptr(wptr_q);
            if (do_pop)  rptr_q <= next_ptr(rptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset: count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: issues word fetches to a 1-cycle memory under a credit limit,
// buffers the returns and presents pc/inst/valid to IF/ID; jmp flushes and redirects.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input logic         clk,
    input logic         resetn,
    if_fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              infl_epoch_q, infl_epoch_d;

    logic [CW-1:0]     count;
    logic [CW:0]       credit;
    fetch_entry_t      head, push_entry;
    logic              have, pop, push, issue;

    assign have = (count != '0);
    assign pop  = have && !bus.stall;

    // Slots claimed after this edge: buffered + returning now - leaving now.
    assign credit = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue  = resetn && !bus.jmp && (credit < (CW + 1)'(DEPTH));

    // Returns tagged with a stale epoch belong to a path abandoned by jmp.
    assign push       = inflight_q && (infl_epoch_q == epoch_q);
    assign push_entry = '{pc: infl_pc_q, inst: bus.imem_rdata};

    always_comb begin
        fpc_d        = fpc_q;
        inflight_d   = 1'b0;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = infl_epoch_q;
        epoch_d      = epoch_q;
        if (bus.jmp) begin
            fpc_d   = align_word(bus.jmp_target);
            epoch_d = ~epoch_q;
        end else if (issue) begin
            fpc_d        = fpc_q + PC_STEP;
            inflight_d   = 1'b1;
            infl_pc_d    = fpc_q;
            infl_epoch_d = epoch_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fpc_q        <= RESET_PC;
            inflight_q   <= 1'b0;
            infl_pc_q    <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_epoch_q <= 1'b0;
        end else begin
            fpc_q        <= fpc_d;
            inflight_q   <= inflight_d;
            infl_pc_q    <= infl_pc_d;
            epoch_q      <= epoch_d;
            infl_epoch_q <= infl_epoch_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (bus.jmp),
        .count_o (count),
        .head_o  (head)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fpc_q;
    assign bus.valid     = have;
    assign bus.pc        = have ? head.pc   : '0;
    assign bus.inst      = have ? head.inst : NOP_INST;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle table for the main fetch/stall/redirect flow, scoreboard of
// consumed instructions, plus hand sequences for mid-stream reset and PC wrap-around.
module tb_if_fetch;
    import if_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic rst1_n;

    always #5 clk = ~clk;

    if_fetch_if bus0();
    if_fetch_if bus1();

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk    (clk),
        .resetn (rst1_n),
        .bus    (bus1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    // 1-cycle synchronous instruction memories.
    always @(posedge clk) if (bus0.imem_req) bus0.imem_rdata <= mem_word(bus0.imem_addr);
    always @(posedge clk) if (bus1.imem_req) bus1.imem_rdata <= mem_word(bus1.imem_addr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of instructions IF/ID should consume, in program order.
    logic [31:0] exp_q[$];
    logic        mon_en;

    always @(negedge clk) begin
        if (mon_en && bus0.valid && !bus0.stall && !bus0.jmp) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: got pc %h consumed, expected none", bus0.pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", bus0.pc, e);
                chk("sb_inst", bus0.inst, mem_word(e));
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        jmp;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        push_en;
        logic [31:0] push_pc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic s, input logic j, input logic [31:0] t,
                                input logic rq, input logic [31:0] ad,
                                input logic v, input logic [31:0] p,
                                input logic pe, input logic [31:0] pp);
        vec_t r;
        r.stall = s;  r.jmp = j;  r.tgt = t;
        r.exp_req = rq;  r.exp_addr = ad;
        r.exp_valid = v;  r.exp_pc = p;
        r.push_en = pe;  r.push_pc = pp;
        return r;
    endfunction

    initial begin
        logic [31:0] wpc;

        resetn = 1'b0;
        rst1_n = 1'b0;
        mon_en = 1'b1;
        bus0.stall = 1'b0;  bus0.jmp = 1'b0;  bus0.jmp_target = '0;
        bus1.stall = 1'b0;  bus1.jmp = 1'b0;  bus1.jmp_target = '0;

        //            stall jmp target       req addr          valid pc       push pc
        tbl[0]  = mk(0, 0, 32'h0,     1, 32'h000,   0, 32'h0,   1, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,     1, 32'h004,   0, 32'h0,   1, 32'h4);
        tbl[2]  = mk(0, 0, 32'h0,     1, 32'h008,   1, 32'h0,   1, 32'h8);
        tbl[3]  = mk(0, 0, 32'h0,     1, 32'h00C,   1, 32'h4,   1, 32'hC);
        tbl[4]  = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h8,   0, 32'h0);
        tbl[5]  = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h8,   0, 32'h0);
        tbl[6]  = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h8,   0, 32'h0);
        tbl[7]  = mk(0, 0, 32'h0,     1, 32'h010,   1, 32'h8,   0, 32'h0);
        tbl[8]  = mk(0, 0, 32'h0,     1, 32'h014,   1, 32'hC,   0, 32'h0);
        tbl[9]  = mk(0, 1, 32'h100,   0, 32'h0,     1, 32'h10,  1, 32'h100);
        tbl[10] = mk(0, 0, 32'h0,     1, 32'h100,   0, 32'h0,   0, 32'h0);
        tbl[11] = mk(0, 0, 32'h0,     1, 32'h104,   0, 32'h0,   0, 32'h0);
        tbl[12] = mk(0, 0, 32'h0,     1, 32'h108,   1, 32'h100, 0, 32'h0);
        tbl[13] = mk(1, 1, 32'h203,   0, 32'h0,     1, 32'h104, 1, 32'h200);
        tbl[14] = mk(0, 0, 32'h0,     1, 32'h200,   0, 32'h0,   0, 32'h0);
        tbl[15] = mk(0, 0, 32'h0,     1, 32'h204,   0, 32'h0,   0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,     1, 32'h208,   1, 32'h200, 0, 32'h0);
        tbl[17] = mk(0, 1, 32'h300,   0, 32'h0,     1, 32'h204, 0, 32'h0);
        tbl[18] = mk(0, 1, 32'h400,   0, 32'h0,     0, 32'h0,   1, 32'h400);
        tbl[19] = mk(0, 0, 32'h0,     1, 32'h400,   0, 32'h0,   0, 32'h0);
        tbl[20] = mk(0, 0, 32'h0,     1, 32'h404,   0, 32'h0,   0, 32'h0);
        tbl[21] = mk(0, 0, 32'h0,     1, 32'h408,   1, 32'h400, 0, 32'h0);
        tbl[22] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h404, 0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(bus0.imem_req), 32'h0);
        chk("rst_addr",  bus0.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus0.valid), 32'h0);
        chk("rst_pc",    bus0.pc, 32'h0);
        chk("rst_inst",  bus0.inst, 32'h0);
        chk("rst1_req",  32'(bus1.imem_req), 32'h0);
        chk("rst1_addr", bus1.imem_addr, 32'hFFFF_FFF8);

        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus0.stall      = tbl[i].stall;
            bus0.jmp        = tbl[i].jmp;
            bus0.jmp_target = tbl[i].tgt;
            if (tbl[i].push_en) exp_q.push_back(tbl[i].push_pc);
            @(negedge clk);
            chk($sformatf("c%0d_req", i), 32'(bus0.imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("c%0d_addr", i), bus0.imem_addr, tbl[i].exp_addr);
            chk($sformatf("c%0d_valid", i), 32'(bus0.valid), 32'(tbl[i].exp_valid));
            chk($sformatf("c%0d_pc", i), bus0.pc, tbl[i].exp_pc);
            chk($sformatf("c%0d_inst", i), bus0.inst,
                tbl[i].exp_valid ? mem_word(tbl[i].exp_pc) : 32'h0);
            @(posedge clk);
            #1;
        end

        // Mid-stream reset with two entries buffered under stall.
        bus0.jmp = 1'b0;
        #2;
        chk("mid_pre_valid", 32'(bus0.valid), 32'h1);
        chk("mid_pre_pc",    bus0.pc, 32'h404);
        resetn = 1'b0;
        #1;
        chk("mid_valid", 32'(bus0.valid), 32'h0);
        chk("mid_pc",    bus0.pc, 32'h0);
        chk("mid_inst",  bus0.inst, 32'h0);
        chk("mid_req",   32'(bus0.imem_req), 32'h0);
        chk("mid_addr",  bus0.imem_addr, 32'h0);

        @(posedge clk);
        #1;
        resetn = 1'b1;
        bus0.stall = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        @(negedge clk);
        chk("rr0_req",   32'(bus0.imem_req), 32'h1);
        chk("rr0_addr",  bus0.imem_addr, 32'h0);
        chk("rr0_valid", 32'(bus0.valid), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr1_addr",  bus0.imem_addr, 32'h4);
        chk("rr1_valid", 32'(bus0.valid), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr2_valid", 32'(bus0.valid), 32'h1);
        chk("rr2_pc",    bus0.pc, 32'h0);
        chk("rr2_inst",  bus0.inst, mem_word(32'h0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr3_pc",    bus0.pc, 32'h4);
        #1 bus0.stall = 1'b1;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        // PC wrap-around on the second instance.
        @(posedge clk);
        #1 rst1_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wpc = 32'hFFFF_FFF8 + 32'(4 * k);
            chk($sformatf("wrap%0d_req", k), 32'(bus1.imem_req), 32'h1);
            chk($sformatf("wrap%0d_addr", k), bus1.imem_addr, wpc);
            if (k >= 2) begin
                wpc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                chk($sformatf("wrap%0d_valid", k), 32'(bus1.valid), 32'h1);
                chk($sformatf("wrap%0d_pc", k), bus1.pc, wpc);
                chk($sformatf("wrap%0d_inst", k), bus1.inst, mem_word(wpc));
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
